// File: rtl/lfsr_pkg.sv
// Shared LFSR definitions for the pseudo-random generator and checker.
// One polynomial definition keeps both ends of the link in agreement.
package lfsr_pkg;

   localparam int LFSR_WIDTH = 3;
   localparam int LFSR_TAP   = 1;

   typedef enum logic [1:0] {
      HUNT   = 2'd0,
      LOCKED = 2'd1,
      STUCK  = 2'd2
   } chk_state_e;

   // Fibonacci step on the low 'width' bits: shift left, feed back tap^msb
   function automatic logic [31:0] lfsr_next(
      input logic [31:0] x,
      input int unsigned width,
      input int unsigned tap
   );
      logic [31:0] mask;
      logic        fb;
      mask = (32'h1 << width) - 32'h1;
      fb   = x[tap] ^ x[width-1];
      return ((x << 1) | {31'b0, fb}) & mask;
   endfunction

endpackage

// File: rtl/lfsr_seq_checker_sat_counter.sv
// Saturating up-counter with synchronous clear taking priority.
module sat_counter #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         i_clr,
   input  logic         i_inc,
   output logic [W-1:0] o_count
);

   logic [W-1:0] r_count;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_count <= '0;
      end else if (i_clr) begin
         r_count <= '0;
      end else if (i_inc && (r_count != '1)) begin
         r_count <= r_count + W'(1);
      end
   end

   assign o_count = r_count;

endmodule

// File: rtl/lfsr_seq_checker.sv
// Sink-side LFSR stream checker: self-synchronises, flywheels a
// reference word and counts mismatches once locked.
module lfsr_seq_checker
   import lfsr_pkg::*;
#(
   parameter int WIDTH    = LFSR_WIDTH,
   parameter int TAP      = LFSR_TAP,
   parameter int LOCK_CNT = 3,
   parameter int LOSS_CNT = 4,
   parameter int ERR_W    = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clear,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] in_data,
   output logic             locked,
   output logic             stuck_zero,
   output logic             err_pulse,
   output logic [ERR_W-1:0] err_count
);

   localparam int GW = $clog2(LOCK_CNT + 2);
   localparam int BW = $clog2(LOSS_CNT + 1);
   localparam logic [GW-1:0] GOOD_MAX = GW'(LOCK_CNT + 1);
   localparam logic [BW-1:0] BAD_MAX  = BW'(LOSS_CNT);

   chk_state_e r_state, w_state_n;
   logic [WIDTH-1:0] r_ref, w_ref_n, w_exp;
   logic [GW-1:0]    r_good, w_good_n, w_good_inc;
   logic [BW-1:0]    r_bad, w_bad_n, w_bad_inc;
   logic             r_locked, r_stuck, r_pulse;
   logic             w_pulse_n, w_inc, w_zero;

   assign w_exp      = WIDTH'(lfsr_next(32'(r_ref), WIDTH, TAP));
   assign w_good_inc = r_good + GW'(1);
   assign w_bad_inc  = r_bad + BW'(1);
   assign w_zero     = (in_data == '0);

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state  <= HUNT;
         r_ref    <= '0;
         r_good   <= '0;
         r_bad    <= '0;
         r_locked <= 1'b0;
         r_stuck  <= 1'b0;
         r_pulse  <= 1'b0;
      end else begin
         r_state  <= w_state_n;
         r_ref    <= w_ref_n;
         r_good   <= w_good_n;
         r_bad    <= w_bad_n;
         r_locked <= (w_state_n == LOCKED);
         r_stuck  <= (w_state_n == STUCK);
         r_pulse  <= w_pulse_n;
      end
   end

   always_comb begin
      w_state_n = r_state;
      w_ref_n   = r_ref;
      w_good_n  = r_good;
      w_bad_n   = r_bad;
      w_pulse_n = 1'b0;
      w_inc     = 1'b0;
      if (in_valid) begin
         unique case (r_state)
            HUNT: begin
               if (w_zero) begin
                  w_state_n = STUCK;
                  w_good_n  = '0;
               end else if (r_good == '0) begin
                  w_ref_n  = in_data;
                  w_good_n = GW'(1);
               end else if (in_data == w_exp) begin
                  w_ref_n  = in_data;
                  w_good_n = w_good_inc;
                  if (w_good_inc == GOOD_MAX) begin
                     w_state_n = LOCKED;
                     w_bad_n   = '0;
                  end
               end else begin
                  w_ref_n  = in_data;
                  w_good_n = GW'(1);
               end
            end
            LOCKED: begin
               // flywheel: reference advances whatever arrives
               w_ref_n = w_exp;
               if (in_data == w_exp) begin
                  w_bad_n = '0;
               end else begin
                  w_pulse_n = 1'b1;
                  w_inc     = 1'b1;
                  w_bad_n   = w_bad_inc;
                  if (w_bad_inc == BAD_MAX) begin
                     if (w_zero) begin
                        w_state_n = STUCK;
                        w_good_n  = '0;
                     end else begin
                        w_state_n = HUNT;
                        w_ref_n   = in_data;
                        w_good_n  = GW'(1);
                     end
                  end
               end
            end
            STUCK: begin
               if (!w_zero) begin
                  w_state_n = HUNT;
                  w_ref_n   = in_data;
                  w_good_n  = GW'(1);
               end
            end
            default: begin
               w_state_n = HUNT;
               w_good_n  = '0;
            end
         endcase
      end
   end

   sat_counter #(
      .W(ERR_W)
   ) u_err_cnt (
      .clk    (clk),
      .reset  (reset),
      .i_clr  (clear),
      .i_inc  (w_inc),
      .o_count(err_count)
   );

   assign locked     = r_locked;
   assign stuck_zero = r_stuck;
   assign err_pulse  = r_pulse;

endmodule

// File: tb/tb_lfsr_seq_checker.sv
// Scoreboard bench for lfsr_seq_checker (default and small-counter builds).
module tb_lfsr_seq_checker;

   typedef struct packed {
      logic       lk;
      logic       st;
      logic       pl;
      logic [7:0] cn;
   } exp_t;

   logic       clk = 1'b0;
   logic       reset, clear, in_valid;
   logic [2:0] in_data;
   logic       locked, stuck_zero, err_pulse;
   logic [7:0] err_count;

   logic       reset2, clear2, in_valid2;
   logic [2:0] in_data2;
   logic       locked2, stuck_zero2, err_pulse2;
   logic [1:0] err_count2;

   int n_total = 0;
   int n_bad   = 0;
   exp_t sb[$];

   int         m_state, m_good, m_bad;
   logic [2:0] m_ref;
   logic [7:0] m_cnt;
   logic       m_pulse;

   always #5 clk = ~clk;

   lfsr_seq_checker dut (
      .clk(clk), .reset(reset), .clear(clear),
      .in_valid(in_valid), .in_data(in_data),
      .locked(locked), .stuck_zero(stuck_zero),
      .err_pulse(err_pulse), .err_count(err_count)
   );

   lfsr_seq_checker #(
      .WIDTH(3), .TAP(1), .LOCK_CNT(3),
      .LOSS_CNT(8), .ERR_W(2)
   ) dut2 (
      .clk(clk), .reset(reset2), .clear(clear2),
      .in_valid(in_valid2), .in_data(in_data2),
      .locked(locked2), .stuck_zero(stuck_zero2),
      .err_pulse(err_pulse2), .err_count(err_count2)
   );

   task automatic chk(input string tag,
                      input logic [31:0] got,
                      input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   function automatic logic [2:0] nx(input logic [2:0] x);
      return {x[1:0], x[1] ^ x[2]};
   endfunction

   task automatic model(input logic rs, input logic v,
                        input logic [2:0] d, input logic c);
      logic       inc;
      logic [2:0] e;
      inc = 1'b0;
      m_pulse = 1'b0;
      if (rs) begin
         m_state = 0; m_ref = 0; m_good = 0; m_bad = 0; m_cnt = 0;
         return;
      end
      if (v) begin
         if (m_state == 0) begin
            if (d == 0) begin
               m_state = 2; m_good = 0;
            end else if (m_good == 0 || d != nx(m_ref)) begin
               m_ref = d; m_good = 1;
            end else begin
               m_ref = d; m_good++;
               if (m_good == 4) begin m_state = 1; m_bad = 0; end
            end
         end else if (m_state == 1) begin
            e = nx(m_ref);
            m_ref = e;
            if (d == e) m_bad = 0;
            else begin
               m_pulse = 1'b1; inc = 1'b1; m_bad++;
               if (m_bad == 4) begin
                  if (d == 0) begin m_state = 2; m_good = 0; end
                  else begin m_state = 0; m_ref = d; m_good = 1; end
               end
            end
         end else if (d != 0) begin
            m_state = 0; m_ref = d; m_good = 1;
         end
      end
      if (c) m_cnt = 0;
      else if (inc && m_cnt != 8'hff) m_cnt++;
   endtask

   task automatic step(input logic rs, input logic v,
                       input logic [2:0] d, input logic c);
      exp_t e;
      reset = rs; in_valid = v; in_data = d; clear = c;
      model(rs, v, d, c);
      e.lk = (m_state == 1);
      e.st = (m_state == 2);
      e.pl = m_pulse;
      e.cn = m_cnt;
      sb.push_back(e);
      @(posedge clk);
      #1;
      if (sb.size() == 0) begin
         chk("sb_empty", 0, 1);
      end else begin
         e = sb.pop_front();
         chk("locked", 32'(locked), 32'(e.lk));
         chk("stuck", 32'(stuck_zero), 32'(e.st));
         chk("pulse", 32'(err_pulse), 32'(e.pl));
         chk("count", 32'(err_count), 32'(e.cn));
      end
   endtask

   task automatic step2(input logic rs, input logic v, input logic [2:0] d);
      reset2 = rs; in_valid2 = v; in_data2 = d; clear2 = 1'b0;
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [2:0] seq2 [10];
      logic [2:0] bad2 [5];
      int         ne;
      reset2 = 1'b1; clear2 = 1'b0; in_valid2 = 1'b0; in_data2 = 3'd0;

      // T1: acquire lock on a clean stream
      step(1, 0, 0, 0);
      chk("t1_rst_lock", 32'(locked), 0);
      chk("t1_rst_cnt", 32'(err_count), 0);
      step(0, 1, 7, 0);
      step(0, 1, 6, 0);
      step(0, 1, 4, 0);
      chk("t1_prelock", 32'(locked), 0);
      step(0, 1, 1, 0);
      chk("t1_lock", 32'(locked), 1);
      step(0, 1, 2, 0);
      step(0, 1, 5, 0);
      step(0, 1, 3, 0);
      step(0, 1, 7, 0);
      step(0, 1, 6, 0);
      step(0, 1, 4, 0);
      step(0, 1, 1, 0);

      // T2: single zero word while locked, flywheel holds
      step(0, 1, 0, 0);
      chk("t2_pulse", 32'(err_pulse), 1);
      chk("t2_cnt", 32'(err_count), 1);
      chk("t2_lock", 32'(locked), 1);
      step(0, 1, 5, 0);
      chk("t2_nopulse", 32'(err_pulse), 0);
      step(0, 1, 3, 0);
      step(0, 0, 3, 0);
      chk("t2_gap_pulse", 32'(err_pulse), 0);
      step(0, 1, 7, 0);
      step(0, 1, 6, 0);
      step(0, 1, 4, 0);
      step(0, 1, 1, 0);

      // T3: four consecutive bad words drop lock, then relock
      for (int i = 0; i < 4; i++) step(0, 1, 6, 0);
      chk("t3_cnt", 32'(err_count), 5);
      chk("t3_unlock", 32'(locked), 0);
      step(0, 1, 6, 0);
      step(0, 1, 4, 0);
      step(0, 1, 1, 0);
      chk("t3_prelock", 32'(locked), 0);
      step(0, 1, 2, 0);
      chk("t3_relock", 32'(locked), 1);

      // T5: clear beats increment, pulse still fires
      step(0, 1, 7, 1);
      chk("t5_pulse", 32'(err_pulse), 1);
      chk("t5_cnt", 32'(err_count), 0);
      step(0, 1, 1, 0);
      chk("t5_cnt1", 32'(err_count), 1);

      // T4: zero stream lands in STUCK, then recovers
      step(1, 0, 0, 0);
      chk("t4_rst_lock", 32'(locked), 0);
      for (int i = 0; i < 3; i++) step(0, 1, 0, 0);
      chk("t4_stuck", 32'(stuck_zero), 1);
      step(0, 1, 5, 0);
      chk("t4_unstuck", 32'(stuck_zero), 0);
      step(0, 1, 3, 0);
      step(0, 1, 7, 0);
      chk("t4_prelock", 32'(locked), 0);
      step(0, 1, 6, 0);
      chk("t4_lock", 32'(locked), 1);

      // T6: 2-bit counter saturation with valid gaps
      step2(1, 0, 0);
      step2(0, 1, 7);
      step2(0, 1, 6);
      step2(0, 1, 4);
      step2(0, 1, 1);
      chk("t6_lock", 32'(locked2), 1);
      seq2 = '{3'd2, 3'd5, 3'd3, 3'd7, 3'd6,
               3'd4, 3'd1, 3'd2, 3'd5, 3'd3};
      bad2 = '{3'd3, 3'd2, 3'd7, 3'd0, 3'd4};
      ne = 0;
      for (int i = 0; i < 10; i++) begin
         if (i % 2 == 0) begin
            step2(0, 1, bad2[i/2]);
            ne++;
            chk("t6_pulse", 32'(err_pulse2), 1);
            chk("t6_cnt", 32'(err_count2), (ne > 3) ? 3 : ne);
         end else begin
            step2(0, 1, seq2[i]);
            chk("t6_okpulse", 32'(err_pulse2), 0);
         end
         step2(0, 0, 0);
         chk("t6_gap_pulse", 32'(err_pulse2), 0);
         chk("t6_gap_lock", 32'(locked2), 1);
      end
      chk("t6_sat", 32'(err_count2), 3);
      step2(1, 0, 0);
      chk("t6_rst_lock", 32'(locked2), 0);
      chk("t6_rst_cnt", 32'(err_count2), 0);
      chk("t6_rst_pulse", 32'(err_pulse2), 0);
      chk("t6_rst_stuck", 32'(stuck_zero2), 0);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
